match_clock_scoreboard: RTL
===========================

# match_clock_scoreboard

Match timer and score keeper for the soccer game. It consumes the game-control FSM's `GameStart` and `WipeScore` level outputs plus single-cycle goal pulses from the ball/goal logic. It produces `TimeOver` back to the FSM, and drives second-count and score values to the HUD renderer. It is the counterpart that closes the FSM's `gameon` loop.

## Interface
- `CLK_HZ`, default 50_000_000: Clk cycles per game second; must be ≥ 2.
- `MATCH_SECONDS`, default 90: match length in seconds; range 1..127.
- `SCORE_MAX`, default 9: per-side score saturation value; range 1..15.

- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high. Clock is `Clk`.
- `GameStart` in 1: level; match may run while high.
- `WipeScore` in 1: level; clears scores and reloads the timer.
- `GoalLeft` in 1: one-cycle pulse; left player scored.
- `GoalRight` in 1: one-cycle pulse; right player scored.
- `TimeOver` out 1: level; match finished.
- `SecondsLeft` out 7: remaining seconds, unsigned binary.
- `ScoreLeft` out 4: left score.
- `ScoreRight` out 4: right score.
- `TickSecond` out 1: one-cycle strobe on each second decrement.
- `Overtime` out 1: golden-goal period active. Tied 0 without the macro.

## Operation
- States: IDLE, RUNNING, EXPIRED, and OVERTIME (macro only).
- Reset values:
  - state = IDLE.
  - prescaler = 0.
  - `SecondsLeft` = MATCH_SECONDS.
  - `ScoreLeft` = `ScoreRight` = 0.
  - `TimeOver` = `Overtime` = `TickSecond` = 0.
- `WipeScore` = 1 has highest priority in every state. Next edge: scores = 0, `SecondsLeft` = MATCH_SECONDS, prescaler = 0, state = IDLE.
- IDLE → RUNNING when `GameStart` = 1 and `WipeScore` = 0.
- RUNNING → IDLE when `GameStart` = 0 (pause). Timer, prescaler and scores hold; resuming continues from the held values.
- RUNNING: the prescaler counts 0..CLK_HZ-1 and wraps.
  - At terminal count, `SecondsLeft` decrements.
  - At the decrement from 1 to 0, state → EXPIRED on the same edge.
- Goals are counted only in RUNNING and OVERTIME.
  - Each pulse increments its side by 1, saturating at SCORE_MAX.
  - Simultaneous `GoalLeft` and `GoalRight` increment both sides.
  - A goal in the same cycle as the final tick is counted.
- Goals in IDLE or EXPIRED are ignored.
- EXPIRED: scores and `SecondsLeft` = 0 are frozen. Exit only via `WipeScore`; `GameStart` is ignored.
- `TimeOver` = 1 exactly while state = EXPIRED.
- Arithmetic: `SecondsLeft` never wraps below 0, and scores never exceed SCORE_MAX. Comparisons for the tie check use post-increment scores.

## Timing
- `TimeOver` is registered. It rises the cycle after the edge where `SecondsLeft` goes 1 → 0, so `SecondsLeft` = 0 and `TimeOver` = 1 appear together.
- `TickSecond` is combinational. It is high in the RUNNING cycle with prescaler = CLK_HZ-1, and `SecondsLeft` updates at that cycle's closing edge.
- A full match from IDLE with `GameStart` held high takes 1 + MATCH_SECONDS × CLK_HZ cycles to `TimeOver` rising. The 1 is the IDLE→RUNNING cycle.
- Scores update on the edge closing the goal-pulse cycle and are visible the next cycle.
- `WipeScore` and a final tick in the same cycle: wipe wins, `TimeOver` stays 0.
- `Reset` mid-match: all outputs return to reset values next cycle.

## Configuration
- Macro: `SCOREBOARD_GOLDEN_GOAL_EN`.
- Defined:
  - At the final tick, if post-increment scores are equal, state → OVERTIME instead of EXPIRED.
  - In OVERTIME, `Overtime` = 1, `SecondsLeft` holds 0, the prescaler is idle, and `TickSecond` = 0.
  - A goal leaving the scores unequal moves state to EXPIRED next edge.
  - Simultaneous goals that keep the tie, or a goal blocked by saturation that keeps the tie, stay in OVERTIME.
  - `GameStart` = 0 in OVERTIME pauses: goals are ignored while low.
- Undefined: OVERTIME is absent, `Overtime` is tied 0, and the final tick always goes to EXPIRED.

## Test plan
All scenarios use CLK_HZ = 4, MATCH_SECONDS = 3, SCORE_MAX = 9.
- Full match: Reset, then `GameStart` = 1 held.
  - `TickSecond` pulses at cycles 4, 8, 12.
  - `SecondsLeft` goes 3 → 2 → 1 → 0.
  - `TimeOver` = 1 from cycle 13 and stays high until `WipeScore` pulses; then `SecondsLeft` = 3 and `TimeOver` = 0.
- Scoring: 10 `GoalLeft` pulses while RUNNING → `ScoreLeft` = 9, saturated. Simultaneous goal pulses → both sides +1. A goal while EXPIRED → no change.
- Pause: drop `GameStart` at `SecondsLeft` = 2 for 20 cycles → `SecondsLeft` stays 2 and no `TickSecond` occurs. Re-raise → decrement resumes after the remaining prescaler count.
- Collision: `WipeScore` = 1 in the final-tick cycle with score 2–1 → scores 0–0, `SecondsLeft` = 3, `TimeOver` never rises.
- Golden goal (macro defined):
  - Score 1–1 at expiry → `Overtime` = 1, `TimeOver` = 0.
  - `GoalRight` → 1–2, then `TimeOver` = 1 and `Overtime` = 0 next cycle.
  - Without the macro, the same stimulus gives `TimeOver` = 1 at cycle 13 and the goal is ignored.
- Reset: assert `Reset` with the match at 2 s and score 3–4 → next cycle IDLE, 0–0, `SecondsLeft` = 3, all flags 0.

Source files
------------

// File: rtl/match_clock_scoreboard.sv
// match_clock_scoreboard: match timer and score keeper; SCOREBOARD_GOLDEN_GOAL_EN adds golden-goal overtime
module match_clock_scoreboard #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int MATCH_SECONDS = 90,
  parameter int SCORE_MAX     = 9
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       GameStart,
  input  logic       WipeScore,
  input  logic       GoalLeft,
  input  logic       GoalRight,
  output logic       TimeOver,
  output logic [6:0] SecondsLeft,
  output logic [3:0] ScoreLeft,
  output logic [3:0] ScoreRight,
  output logic       TickSecond,
  output logic       Overtime
);
  localparam int PW = $clog2(CLK_HZ);
`ifdef SCOREBOARD_GOLDEN_GOAL_EN
  localparam bit GG = 1'b1;
`else
  localparam bit GG = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED, OVERTIME} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic counting;
  logic [3:0] nl, nr;
  assign TickSecond = state == RUNNING && GameStart && !WipeScore && !Reset && presc == PW'(CLK_HZ - 1);
  assign counting = state == RUNNING || (state == OVERTIME && GameStart);
  assign nl = counting && GoalLeft && ScoreLeft != 4'(SCORE_MAX) ? ScoreLeft + 4'd1 : ScoreLeft;
  assign nr = counting && GoalRight && ScoreRight != 4'(SCORE_MAX) ? ScoreRight + 4'd1 : ScoreRight;
  assign TimeOver = state == EXPIRED;
`ifdef SCOREBOARD_GOLDEN_GOAL_EN
  assign Overtime = state == OVERTIME;
`else
  assign Overtime = 1'b0;
`endif
  always_ff @(posedge Clk) begin
    if (Reset || WipeScore) begin
      state       <= IDLE;
      presc       <= '0;
      SecondsLeft <= 7'(MATCH_SECONDS);
      ScoreLeft   <= '0;
      ScoreRight  <= '0;
    end else begin
      ScoreLeft  <= nl;
      ScoreRight <= nr;
      if (state == IDLE && GameStart) state <= RUNNING;
      if (state == RUNNING) begin
        if (!GameStart) state <= IDLE;
        else begin
          presc <= TickSecond ? '0 : presc + PW'(1);
          if (TickSecond && SecondsLeft != 7'd0) SecondsLeft <= SecondsLeft - 7'd1;
          // post-increment scores decide between overtime and a finished match
          if (TickSecond && SecondsLeft == 7'd1) state <= GG && nl == nr ? OVERTIME : EXPIRED;
        end
      end
      if (state == OVERTIME && nl != nr) state <= EXPIRED;
    end
  end
endmodule
